// File: rtl/demux4_stream_if.sv
// Stream bundle for the 1:4 demultiplexer: one select-tagged input stream and four output channels.
// The producer/consumer side uses master; the demux uses slave.
interface demux4_stream_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_sel;
    logic [WIDTH-1:0]     in_data;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [4*WIDTH-1:0]   out_data;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux4_stream.sv
// 1:4 stream demultiplexer with a one-entry register per output channel.
// Only the selected channel gates in_ready, so a stalled consumer never blocks the others.
module demux4_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    demux4_stream_if.slave    s,
    output logic [CNT_W-1:0]  beat_cnt
);
    localparam int unsigned NCH = 4;

    logic [NCH-1:0]    valid_q;
    logic [WIDTH-1:0]  data_q [NCH];
    logic [CNT_W-1:0]  cnt_q;
    logic              rdy_c;
    logic              accept_c;
    logic [NCH-1:0]    load_c;
    logic [NCH-1:0]    pop_c;

    // Handshake decode: a slot can take a beat if empty or draining this cycle.
    always_comb begin
        load_c   = '0;
        rdy_c    = ~rst & (~valid_q[s.in_sel] | s.out_ready[s.in_sel]);
        accept_c = s.in_valid & rdy_c;
        pop_c    = valid_q & s.out_ready;
        if (accept_c) begin
            load_c[s.in_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < NCH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            // A load wins over a pop so a drained slot refills without a bubble.
            for (int k = 0; k < NCH; k++) begin
                if (load_c[k]) begin
                    valid_q[k] <= 1'b1;
                    data_q[k]  <= s.in_data;
                end else if (pop_c[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
            if (accept_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        s.out_data = '0;
        for (int k = 0; k < NCH; k++) begin
            s.out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

    assign s.in_ready  = rdy_c;
    assign s.out_valid = valid_q;
    assign beat_cnt    = cnt_q;

    // Previous-cycle snapshots used by the hold and routing checks below.
    logic [NCH-1:0]    chk_stall_q;
    logic [WIDTH-1:0]  chk_hold_q [NCH];
    logic              chk_acc_q;
    logic [1:0]        chk_sel_q;
    logic [WIDTH-1:0]  chk_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_stall_q <= '0;
            chk_acc_q   <= 1'b0;
        end else begin
            chk_stall_q <= valid_q & ~s.out_ready;
            chk_acc_q   <= accept_c;
        end
        chk_sel_q  <= s.in_sel;
        chk_data_q <= s.in_data;
        for (int k = 0; k < NCH; k++) begin
            chk_hold_q[k] <= data_q[k];
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NCH; k++) begin
                if (chk_stall_q[k]) begin
                    a1_hold: assert (valid_q[k] && data_q[k] == chk_hold_q[k])
                        else $error("A1 ch%0d stalled beat changed at %0t", k, $time);
                end
            end
            if (chk_acc_q) begin
                a2_route: assert (valid_q[chk_sel_q] && data_q[chk_sel_q] == chk_data_q)
                    else $error("A2 ch%0d accepted beat not presented at %0t", chk_sel_q, $time);
            end
            if (s.in_valid) begin
                a4_sel_known: assert (!$isunknown(s.in_sel))
                    else $error("A4 ch%0d select unknown with valid at %0t", s.in_sel, $time);
            end
        end
    end

    a3_one_load: assert property (@(posedge clk) disable iff (rst) $onehot0(load_c))
        else $error("A3 ch-load vector %b not onehot0 at %0t", load_c, $time);

endmodule

// File: tb/tb_demux4_stream.sv
// Bench for demux4_stream: directed vector table, wrap sequence, then random traffic vs a slot model.
module tb_demux4_stream;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] beat_cnt;

    demux4_stream_if #(.WIDTH(WIDTH)) bus ();

    demux4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .s        (bus),
        .beat_cnt (beat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Model: each channel is a single slot that is either empty or holds one beat.
    logic       mv [4];
    logic [7:0] md [4];
    int         mcnt;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_valid;
        logic [3:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [1:0] sel,
                         input logic [7:0] d, input logic [3:0] ordy);
        rst           = r;
        bus.in_valid  = iv;
        bus.in_sel    = sel;
        bus.in_data   = d;
        bus.out_ready = ordy;
    endtask

    function automatic logic model_ready();
        int s = int'(bus.in_sel);
        return !rst && (!mv[s] || bus.out_ready[s]);
    endfunction

    function automatic logic [3:0] model_valid();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = mv[k];
        return v;
    endfunction

    function automatic logic [31:0] model_data();
        logic [31:0] d;
        for (int k = 0; k < 4; k++) d[k*8 +: 8] = md[k];
        return d;
    endfunction

    // Apply the clock-edge rules to the model using the currently driven inputs.
    task automatic model_edge();
        logic acc;
        int   s;
        acc = bus.in_valid && model_ready();
        s   = int'(bus.in_sel);
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                mv[k] = 1'b0;
                md[k] = 8'h00;
            end
            mcnt = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (acc && s == k) begin
                    mv[k] = 1'b1;
                    md[k] = bus.in_data;
                end else if (mv[k] && bus.out_ready[k]) begin
                    mv[k] = 1'b0;
                end
            end
            if (acc) mcnt = (mcnt + 1) % (1 << CNT_W);
        end
    endtask

    task automatic table_step(input vec_t v, input int i);
        drive(v.rst, v.iv, v.sel, v.data, v.ordy);
        #1;
        check($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 32'(v.exp_rdy));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check($sformatf("row%0d out_valid", i), 32'(bus.out_valid), 32'(v.exp_valid));
        check($sformatf("row%0d beat_cnt", i), 32'(beat_cnt), 32'(v.exp_cnt));
        check($sformatf("row%0d out_data", i), bus.out_data, model_data());
    endtask

    task automatic model_step(input logic r, input logic iv, input logic [1:0] sel,
                              input logic [7:0] d, input logic [3:0] ordy, input string tag);
        drive(r, iv, sel, d, ordy);
        #1;
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'(model_ready()));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'(model_valid()));
        check({tag, " out_data"}, bus.out_data, model_data());
        check({tag, " beat_cnt"}, 32'(beat_cnt), 32'(mcnt));
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            mv[k] = 1'b0;
            md[k] = 8'h00;
        end
        mcnt = 0;
        drive(1'b1, 1'b0, 2'd0, 8'h00, 4'h0);

        //             rst   iv    sel   data   ordy     rdy   valid    cnt
        vecs.push_back('{1'b1, 1'b1, 2'd0, 8'hFF, 4'b1111, 1'b0, 4'b0000, 4'd0});
        vecs.push_back('{1'b1, 1'b1, 2'd1, 8'hEE, 4'b1111, 1'b0, 4'b0000, 4'd0});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 8'hA0, 4'b1111, 1'b1, 4'b0001, 4'd1});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 8'hA1, 4'b1111, 1'b1, 4'b0010, 4'd2});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 8'hA2, 4'b1111, 1'b1, 4'b0100, 4'd3});
        vecs.push_back('{1'b0, 1'b1, 2'd3, 8'hA3, 4'b1111, 1'b1, 4'b1000, 4'd4});
        vecs.push_back('{1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 4'd4});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 8'h11, 4'b1011, 1'b1, 4'b0100, 4'd5});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 8'h22, 4'b1011, 1'b0, 4'b0100, 4'd5});
        vecs.push_back('{1'b0, 1'b1, 2'd2, 8'h22, 4'b1111, 1'b1, 4'b0100, 4'd6});
        vecs.push_back('{1'b0, 1'b1, 2'd1, 8'h33, 4'b1101, 1'b1, 4'b0010, 4'd7});
        vecs.push_back('{1'b0, 1'b1, 2'd3, 8'h5A, 4'b0101, 1'b1, 4'b1010, 4'd8});
        vecs.push_back('{1'b0, 1'b1, 2'd0, 8'h77, 4'b0000, 1'b1, 4'b1011, 4'd9});
        vecs.push_back('{1'b1, 1'b1, 2'd2, 8'h99, 4'b0000, 1'b0, 4'b0000, 4'd0});

        @(negedge clk);
        foreach (vecs[i]) table_step(vecs[i], i);

        // Counter wrap: 17 back-to-back beats from zero on a 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            model_step(1'b0, 1'b1, 2'(i % 4), 8'(i), 4'hF, $sformatf("wrap%0d", i));
        end
        check("wrap final beat_cnt", 32'(beat_cnt), 32'h1);

        // Random traffic with occasional reset and arbitrary per-channel backpressure.
        for (int i = 0; i < 1500; i++) begin
            model_step(($urandom_range(0, 49) == 0),
                       ($urandom_range(0, 3) != 0),
                       2'($urandom_range(0, 3)),
                       8'($urandom),
                       4'($urandom),
                       $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
